// File: rtl/ysyx_23060278_ifu.sv
// ysyx_23060278_ifu: instruction fetch unit, one outstanding imem request,
// holds the fetched word for decode and squashes wrong-path fetches on redirect.
module ysyx_23060278_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      r_state, w_state_n;
    logic [31:0] r_pc, w_pc_n, r_inst, w_inst_n, r_inst_pc, w_inst_pc_n;
    logic        r_drop, w_drop_n;
    logic [31:0] w_redir_pc;

    assign w_redir_pc     = {redirect_pc[31:2], 2'b00};
    assign imem_req_addr  = r_pc;
    assign imem_req_valid = (r_state == REQ) && !redirect_valid;
    assign inst_valid     = (r_state == HOLD) && !redirect_valid;
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_drop    <= 1'b0;
            r_inst    <= '0;
            r_inst_pc <= '0;
        end else begin
            r_state   <= w_state_n;
            r_pc      <= w_pc_n;
            r_drop    <= w_drop_n;
            r_inst    <= w_inst_n;
            r_inst_pc <= w_inst_pc_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_pc_n      = redirect_valid ? w_redir_pc : r_pc;
        w_drop_n    = r_drop;
        w_inst_n    = r_inst;
        w_inst_pc_n = r_inst_pc;
        case (r_state)
            IDLE: w_state_n = REQ;
            REQ:  w_state_n = (!redirect_valid && imem_req_ready) ? WAIT : REQ;
            WAIT: begin
                if (imem_rsp_valid) begin
                    // a redirect or pending drop turns this response into wrong-path data
                    if (redirect_valid || r_drop) begin
                        w_drop_n  = 1'b0;
                        w_state_n = REQ;
                    end else begin
                        w_inst_n    = imem_rsp_data;
                        w_inst_pc_n = r_pc;
                        w_pc_n      = r_pc + 32'd4;
                        w_state_n   = HOLD;
                    end
                end else if (redirect_valid) begin
                    w_drop_n = 1'b1;
                end
            end
            HOLD: w_state_n = (redirect_valid || inst_ready) ? REQ : HOLD;
            default: w_state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ysyx_23060278_ifu.sv
// tb_ysyx_23060278_ifu: directed tests with a latency-programmable memory model
// and a scoreboard of expected {pc, inst} pairs consumed at decode handshakes.
module tb_ysyx_23060278_ifu;
    logic        clk = 0;
    logic        rst_n = 1;
    logic        imem_req_valid, imem_req_ready = 1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 0;
    logic [31:0] imem_rsp_data = 0;
    logic        inst_valid, inst_ready = 1;
    logic [31:0] inst, inst_pc;
    logic        redirect_valid = 0;
    logic [31:0] redirect_pc = 0;

    int          n_chk = 0, n_err = 0, n_hs = 0;
    logic [63:0] exp_q[$];
    logic        pend = 0, sq = 0;
    logic [31:0] paddr = 0, s_inst, s_pc, cur_addr;
    int          cnt = 0, lat = 1;

    ysyx_23060278_ifu dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0013 : a ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        logic        hs, take;
        logic [63:0] e;
        #1;
        hs = imem_req_valid && imem_req_ready;
        if (redirect_valid) begin
            exp_q.delete();
            if (pend || imem_rsp_valid) sq = 1;
        end
        take = imem_rsp_valid && !sq && !redirect_valid && rst_n;
        if (inst_valid && inst_ready) begin
            n_hs++;
            if (exp_q.size() == 0) check("inst_unexp", {31'b0, inst_valid}, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("inst", inst, e[31:0]);
                check("inst_pc", inst_pc, e[63:32]);
            end
        end
        cur_addr = imem_req_addr;
        @(posedge clk);
        #1;
        if (take) exp_q.push_back({paddr, mem(paddr)});
        if (imem_rsp_valid) sq = 0;
        imem_rsp_valid = 0;
        redirect_valid = 0;
        if (hs) begin
            pend = 1; paddr = cur_addr; cnt = lat;
        end
        if (pend) begin
            if (cnt <= 1) begin
                imem_rsp_valid = 1; imem_rsp_data = mem(paddr); pend = 0;
            end else cnt--;
        end
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp);
        int n = 0;
        #1;
        while (!imem_req_valid && n < 20) begin step(); n++; #1; end
        check({tag, "_valid"}, {31'b0, imem_req_valid}, 32'd1);
        check(tag, imem_req_addr, exp);
    endtask

    task automatic wait_inst(input string tag);
        int n = 0;
        #1;
        while (!inst_valid && n < 20) begin step(); n++; #1; end
        check(tag, {31'b0, inst_valid}, 32'd1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_reqv"}, {31'b0, imem_req_valid}, 32'd0);
        check({tag, "_instv"}, {31'b0, inst_valid}, 32'd0);
        check({tag, "_addr"}, imem_req_addr, 32'h8000_0000);
        check({tag, "_inst"}, inst, 32'd0);
        check({tag, "_pc"}, inst_pc, 32'd0);
    endtask

    initial begin
        int hs0;
        #2 rst_n = 0;
        #1 check_reset("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // basic fetch
        wait_req("t1_req0", 32'h8000_0000);
        wait_inst("t1_iv");
        check("t1_inst", inst, 32'h0000_0013);
        check("t1_pc", inst_pc, 32'h8000_0000);
        step();
        wait_req("t1_req1", 32'h8000_0004);

        // decoder stall in HOLD
        inst_ready = 0;
        wait_inst("t2_iv");
        s_inst = inst; s_pc = inst_pc;
        check("t2_pc0", inst_pc, 32'h8000_0004);
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            check("t2_iv_hold", {31'b0, inst_valid}, 32'd1);
            check("t2_inst_hold", inst, s_inst);
            check("t2_pc_hold", inst_pc, s_pc);
            check("t2_noreq", {31'b0, imem_req_valid}, 32'd0);
        end
        inst_ready = 1;
        step();
        wait_req("t2_next", 32'h8000_0008);

        // redirect while waiting on a slow response
        lat = 3;
        step();
        redirect_valid = 1; redirect_pc = 32'h8000_0100;
        step();
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (imem_req_valid) break;
            check("t3_noinst", {31'b0, inst_valid}, 32'd0);
            step();
        end
        wait_req("t3_req", 32'h8000_0100);
        wait_inst("t3_iv");
        step();

        // redirect overrides inst_ready in HOLD, low bits cleared
        wait_req("t4_req0", 32'h8000_0104);
        inst_ready = 0;
        wait_inst("t4_iv");
        hs0 = n_hs;
        inst_ready = 1; redirect_valid = 1; redirect_pc = 32'h8000_0203;
        #1 check("t4_iv_squash", {31'b0, inst_valid}, 32'd0);
        step();
        check("t4_no_hs", n_hs, hs0);
        wait_req("t4_req", 32'h8000_0200);
        wait_inst("t4_iv2");
        step();

        // redirect in REQ, then pc wrap
        wait_req("t5_req0", 32'h8000_0204);
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
        #1 check("t5_req_block", {31'b0, imem_req_valid}, 32'd0);
        step();
        wait_req("t5_top", 32'hFFFF_FFFC);
        wait_inst("t5_iv");
        check("t5_pc", inst_pc, 32'hFFFF_FFFC);
        step();
        wait_req("t5_wrap", 32'h0000_0000);

        // reset during WAIT, stale response afterwards
        lat = 4;
        step();
        step();
        rst_n = 0; imem_req_ready = 0; sq = 1;
        #1 check_reset("t6_rst");
        step();
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            check("t6_noinst", {31'b0, inst_valid}, 32'd0);
        end
        lat = 1; imem_req_ready = 1;
        wait_req("t6_req", 32'h8000_0000);
        wait_inst("t6_iv");
        check("t6_inst", inst, 32'h0000_0013);
        step();
        check("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_23060278_ifu.md
Name: ysyx_23060278_ifu

Overview:
Instruction fetch unit directly upstream of the instruction decoder in the NPC core. It holds the PC and issues one 32-bit fetch at a time to instruction memory over a valid/ready request channel plus a valid-only response channel. It presents the fetched word with its PC to decode through a valid/ready handshake. It accepts redirects (branch, jump, trap) from later stages and squashes wrong-path fetches.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  fetch address (current PC)
imem_rsp_valid  input  1  response data valid (one pulse per accepted request)
imem_rsp_data  input  32  fetched instruction word
inst_valid  output  1  instruction available to decoder
inst_ready  input  1  decoder consumes instruction this cycle
inst  output  32  instruction word to decoder
inst_pc  output  32  PC of inst
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  new fetch target

Behaviour:
- State registers: pc[31:0], state in {IDLE, REQ, WAIT, HOLD}, drop flag, inst_q[31:0], inst_pc_q[31:0].
- Reset (rst_n=0, asynchronous): pc=RESET_PC, state=IDLE, drop=0, inst_q=0, inst_pc_q=0. Outputs during reset: imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, imem_req_addr=RESET_PC.
- imem_req_addr = pc at all times. inst = inst_q, inst_pc = inst_pc_q; both stay stable for the whole time state is HOLD.
- imem_req_valid = (state==REQ) && !redirect_valid.
- inst_valid = (state==HOLD) && !redirect_valid.
- IDLE: unconditionally moves to REQ on the next edge. A redirect in IDLE loads pc.
- REQ: a handshake (imem_req_valid && imem_req_ready) moves to WAIT. A redirect loads pc=redirect_pc and stays in REQ; no request is accepted that cycle. The memory side tolerates withdrawal of valid.
- WAIT, response arrives (imem_rsp_valid=1):
  - drop=0: inst_q=imem_rsp_data, inst_pc_q=pc, pc=pc+4, go to HOLD.
  - drop=1: discard the data, clear drop, go to REQ.
- WAIT, redirect with no response: pc=redirect_pc, drop=1, stay in WAIT.
- WAIT, redirect and response in the same cycle: discard the data, pc=redirect_pc, drop=0, go to REQ.
- HOLD: inst_ready=1 with no redirect goes to REQ; the new request is presented the following cycle. A redirect overrides inst_ready: the held instruction is squashed (never handshaken), pc=redirect_pc, go to REQ.
- redirect_pc[1:0] are forced to 2'b00 when loaded into pc.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- At most one request is outstanding. imem_rsp_valid is ignored in IDLE, REQ and HOLD.
- Response latency is at least 1 cycle after the accepting edge. Best-case throughput is one instruction per 3 cycles (REQ, WAIT, HOLD).
- Reset asserted mid-operation aborts any in-flight fetch. A late response arriving after reset is ignored because state is not WAIT.

Test Plan:
- Reset, memory always ready, 1-cycle response returning 32'h00000013 -> first request addr 8000_0000, then inst_valid=1 with inst=32'h00000013 and inst_pc=8000_0000; next request addr 8000_0004.
- Hold inst_ready=0 for 5 cycles while in HOLD -> inst, inst_pc and inst_valid stable; no new imem request; after inst_ready=1, next addr = previous+4.
- Redirect to 32'h8000_0100 while in WAIT, response arrives 3 cycles later -> response discarded, inst_valid never asserts for it, next request addr 8000_0100.
- Redirect to 32'h8000_0203 together with inst_ready=1 in HOLD -> no handshake counted, next request addr 8000_0200.
- pc preset through a redirect to FFFF_FFFC, fetch completes -> following request addr 0000_0000.
- Assert rst_n=0 during WAIT, deassert, then the stale response arrives -> response ignored; request reissued at 8000_0000.
